// File: rtl/lz4_input_packer_if.sv
// lz4_input_packer_if: byte-stream input and dictionary-buffer write port of
// the LZ4 input packer, plus the block-completion report.
//   in_data/in_valid/in_last/in_ready  - byte stream, accepted on valid && ready
//   buf_idata/buf_ivalid               - packed word write strobe to the buffer
//   buf_full/buf_unable                - buffer back-pressure / clearing
//   blk_done/blk_bytes                 - block completion pulse and byte count
// master = packer side, slave = stream source / buffer side.
interface lz4_input_packer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] buf_idata;
  logic        buf_ivalid;
  logic        buf_full;
  logic        buf_unable;
  logic        blk_done;
  logic [16:0] blk_bytes;

  modport master (
    input  in_data, in_valid, in_last, buf_full, buf_unable,
    output in_ready, buf_idata, buf_ivalid, blk_done, blk_bytes
  );

  modport slave (
    output in_data, in_valid, in_last, buf_full, buf_unable,
    input  in_ready, buf_idata, buf_ivalid, blk_done, blk_bytes
  );
endinterface

// File: rtl/lz4_input_packer.sv
// lz4_input_packer: packs the raw input byte stream into 32-bit big-endian
// words (first byte in [31:24]), queues them in a small word FIFO and writes
// them into the LZ4 dictionary buffer. Blocks are delimited at in_last or at
// 65536 bytes; each block's byte count is reported with its final word.
// Ports:
//   clk       - system clock, rising edge
//   rstN      - asynchronous active-low reset
//   pk_clear  - synchronous clear (issued together with the buffer clear)
//   bus       - stream / buffer / block-report signals (master modport)
module lz4_input_packer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rstN,
  input logic                pk_clear,
  lz4_input_packer_if.master bus
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned BYTES_W = 17;
  localparam logic [BYTES_W-1:0] BLK_MAX = 17'h10000;

  typedef struct packed {
    logic [31:0]        word;
    logic               last;
    logic [BYTES_W-1:0] bytes;
  } entry_t;

  logic               rst_state;
  logic [1:0]         lane;
  logic [31:0]        pack_q;
  logic [BYTES_W-1:0] blk_cnt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  entry_t             fifo_mem [FIFO_DEPTH];

  logic [31:0]        idata_q;
  logic               ivalid_q;
  logic               done_q;
  logic [BYTES_W-1:0] bytes_q;

  logic               ready_c;
  logic               accept;
  logic [31:0]        word_next;
  logic [BYTES_W-1:0] cnt_next;
  logic               blk_end;
  logic               push;
  logic               pop;
  entry_t             push_entry;
  entry_t             head;

  // One free entry suffices: at most one word is pushed per cycle.
  assign ready_c = !rst_state && !pk_clear && (fifo_cnt < CNT_W'(FIFO_DEPTH));

  assign bus.in_ready   = ready_c;
  assign bus.buf_idata  = idata_q;
  assign bus.buf_ivalid = ivalid_q;
  assign bus.blk_done   = done_q;
  assign bus.blk_bytes  = bytes_q;

  assign head = fifo_mem[rd_ptr];

  // Byte lane insertion, push / block-end decisions and pop condition.
  always_comb begin
    word_next = pack_q;
    unique case (lane)
      2'd0:    word_next[31:24] = bus.in_data;
      2'd1:    word_next[23:16] = bus.in_data;
      2'd2:    word_next[15:8]  = bus.in_data;
      default: word_next[7:0]   = bus.in_data;
    endcase
    accept   = bus.in_valid && ready_c;
    cnt_next = blk_cnt + BYTES_W'(1);
    blk_end  = accept && (bus.in_last || (cnt_next == BLK_MAX));
    push     = accept && ((lane == 2'd3) || blk_end);
    pop      = (fifo_cnt != '0) && !bus.buf_full && !bus.buf_unable;
    push_entry.word  = word_next;
    push_entry.last  = blk_end;
    push_entry.bytes = cnt_next;
  end

  // FIFO storage; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  // Packing state, FIFO control and registered buffer-side outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rst_state <= 1'b1;
      lane      <= '0;
      pack_q    <= '0;
      blk_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      idata_q   <= '0;
      ivalid_q  <= 1'b0;
      done_q    <= 1'b0;
      bytes_q   <= '0;
    end else begin
      rst_state <= 1'b0;
      if (pk_clear) begin
        lane     <= '0;
        pack_q   <= '0;
        blk_cnt  <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
        ivalid_q <= 1'b0;
        done_q   <= 1'b0;
        bytes_q  <= '0;
      end else begin
        if (accept) begin
          if (push) begin
            lane   <= '0;
            pack_q <= '0;
          end else begin
            lane   <= lane + 2'd1;
            pack_q <= word_next;
          end
          blk_cnt <= blk_end ? '0 : cnt_next;
        end

        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end

        unique case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
          2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
          default: fifo_cnt <= fifo_cnt;
        endcase

        // blk_bytes only moves with the final word of a block.
        if (pop) begin
          idata_q  <= head.word;
          ivalid_q <= 1'b1;
          done_q   <= head.last;
          if (head.last) begin
            bytes_q <= head.bytes;
          end
        end else begin
          ivalid_q <= 1'b0;
          done_q   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lz4_input_packer.sv
// tb_lz4_input_packer: directed bench for lz4_input_packer. Each scenario task
// drives stimulus and compares observed words / flags against hand-computed
// values; a negedge monitor records every buf_ivalid pulse.
module tb_lz4_input_packer;

  logic clk = 1'b0;
  logic rstN;
  logic pk_clear;

  lz4_input_packer_if bus();

  lz4_input_packer #(.FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .pk_clear (pk_clear),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        done;
    logic [16:0] bytes;
    int unsigned stamp;
  } rec_t;

  rec_t q[$];

  always @(negedge clk) begin
    if (bus.buf_ivalid === 1'b1) begin
      q.push_back('{bus.buf_idata, bus.blk_done, bus.blk_bytes, cyc});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout byte=%h in_ready=%b required=1", d, bus.in_ready);
    end else begin
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    pk_clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.in_last = 1'b0;
    bus.buf_full = 1'b0;
    bus.buf_unable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.buf_idata !== 32'h0) begin miscompares++; $display("FAIL reset_idata got=%h required=%h", bus.buf_idata, 32'h0); end
    vectors++;
    if (bus.buf_ivalid !== 1'b0) begin miscompares++; $display("FAIL reset_ivalid got=%b required=0", bus.buf_ivalid); end
    vectors++;
    if (bus.blk_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b required=0", bus.blk_done); end
    vectors++;
    if (bus.blk_bytes !== 17'd0) begin miscompares++; $display("FAIL reset_bytes got=%0d required=0", bus.blk_bytes); end
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b required=0", bus.in_ready); end
    #2;
    rstN = 1'b1;
    step();
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got=%b required=1", bus.in_ready); end
  endtask

  task automatic test_aligned();
    int unsigned k = 0;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i), i == 7);
      if (i == 3) k = cyc;
    end
    repeat (6) step();
    vectors++;
    if (q.size() != 2) begin
      miscompares++; $display("FAIL aligned_count got=%0d required=2", q.size());
    end else begin
      vectors++;
      if (q[0].data !== 32'h00010203 || q[0].done !== 1'b0) begin
        miscompares++; $display("FAIL aligned_w0 got=%h/%b required=00010203/0", q[0].data, q[0].done);
      end
      vectors++;
      if (q[0].stamp != k + 1) begin
        miscompares++; $display("FAIL aligned_latency got=%0d required=%0d", q[0].stamp, k + 1);
      end
      vectors++;
      if (q[1].data !== 32'h04050607 || q[1].done !== 1'b1 || q[1].bytes !== 17'd8) begin
        miscompares++; $display("FAIL aligned_w1 got=%h/%b/%0d required=04050607/1/8", q[1].data, q[1].done, q[1].bytes);
      end
    end
  endtask

  task automatic test_partial();
    q.delete();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    repeat (5) step();
    vectors++;
    if (q.size() != 1) begin
      miscompares++; $display("FAIL partial_count got=%0d required=1", q.size());
    end else begin
      vectors++;
      if (q[0].data !== 32'hAABBCC00 || q[0].done !== 1'b1 || q[0].bytes !== 17'd3) begin
        miscompares++; $display("FAIL partial_word got=%h/%b/%0d required=aabbcc00/1/3", q[0].data, q[0].done, q[0].bytes);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w;
    q.delete();
    bus.buf_full = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0);
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_drop got=%b required=0", bus.in_ready); end
    repeat (5) step();
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_hold got=%b required=0", bus.in_ready); end
    vectors++;
    if (q.size() != 0) begin miscompares++; $display("FAIL bp_no_pulse got=%0d required=0", q.size()); end
    bus.buf_full = 1'b0;
    step();
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_return got=%b required=1", bus.in_ready); end
    for (int i = 16; i < 20; i++) send_byte(8'(8'h10 + i), i == 19);
    repeat (8) step();
    vectors++;
    if (q.size() != 5) begin
      miscompares++; $display("FAIL bp_count got=%0d required=5", q.size());
    end else begin
      for (int w = 0; w < 5; w++) begin
        exp_w = {8'(8'h10 + 4*w), 8'(8'h11 + 4*w), 8'(8'h12 + 4*w), 8'(8'h13 + 4*w)};
        vectors++;
        if (q[w].data !== exp_w) begin
          miscompares++; $display("FAIL bp_word%0d got=%h required=%h", w, q[w].data, exp_w);
        end
      end
      vectors++;
      if (q[1].stamp != q[0].stamp + 1 || q[2].stamp != q[0].stamp + 2 || q[3].stamp != q[0].stamp + 3) begin
        miscompares++; $display("FAIL bp_consecutive got=%0d,%0d,%0d,%0d required=consecutive", q[0].stamp, q[1].stamp, q[2].stamp, q[3].stamp);
      end
      vectors++;
      if (q[3].done !== 1'b0 || q[4].done !== 1'b1 || q[4].bytes !== 17'd20) begin
        miscompares++; $display("FAIL bp_block got=%b/%b/%0d required=0/1/20", q[3].done, q[4].done, q[4].bytes);
      end
    end
  endtask

  task automatic test_split_64k();
    int unsigned errs = 0;
    int unsigned dones = 0;
    logic [31:0] exp_w;
    q.delete();
    for (int i = 0; i < 65540; i++) send_byte(8'(i), i == 65539);
    repeat (6) step();
    vectors++;
    if (q.size() != 16385) begin
      miscompares++; $display("FAIL split_count got=%0d required=16385", q.size());
    end else begin
      for (int w = 0; w < 16385; w++) begin
        exp_w = {8'(4*w), 8'(4*w + 1), 8'(4*w + 2), 8'(4*w + 3)};
        if (q[w].data !== exp_w) errs++;
        if (q[w].done === 1'b1) dones++;
      end
      vectors++;
      if (errs != 0) begin miscompares++; $display("FAIL split_data got=%0d bad words required=0", errs); end
      vectors++;
      if (dones != 2) begin miscompares++; $display("FAIL split_done_count got=%0d required=2", dones); end
      vectors++;
      if (q[16383].done !== 1'b1 || q[16383].bytes !== 17'h10000) begin
        miscompares++; $display("FAIL split_first_block got=%b/%0d required=1/65536", q[16383].done, q[16383].bytes);
      end
      vectors++;
      if (q[16384].done !== 1'b1 || q[16384].bytes !== 17'd4 || q[16384].data !== 32'h00010203) begin
        miscompares++; $display("FAIL split_second_block got=%b/%0d/%h required=1/4/00010203", q[16384].done, q[16384].bytes, q[16384].data);
      end
    end
  endtask

  task automatic test_clear();
    q.delete();
    bus.buf_unable = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'(8'h60 + i), 1'b0);
    pk_clear = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL clear_in_ready got=%b required=0", bus.in_ready); end
    step();
    pk_clear = 1'b0;
    repeat (7) step();
    vectors++;
    if (q.size() != 0) begin miscompares++; $display("FAIL clear_no_pulse got=%0d required=0", q.size()); end
    vectors++;
    if (bus.blk_bytes !== 17'd0) begin miscompares++; $display("FAIL clear_bytes got=%0d required=0", bus.blk_bytes); end
    bus.buf_unable = 1'b0;
    repeat (3) step();
    vectors++;
    if (q.size() != 0) begin miscompares++; $display("FAIL clear_fifo_empty got=%0d required=0", q.size()); end
    send_byte(8'h51, 1'b0);
    send_byte(8'h52, 1'b0);
    send_byte(8'h53, 1'b0);
    send_byte(8'h54, 1'b1);
    repeat (5) step();
    vectors++;
    if (q.size() != 1) begin
      miscompares++; $display("FAIL clear_next_count got=%0d required=1", q.size());
    end else begin
      vectors++;
      if (q[0].data !== 32'h51525354 || q[0].done !== 1'b1 || q[0].bytes !== 17'd4) begin
        miscompares++; $display("FAIL clear_next_word got=%h/%b/%0d required=51525354/1/4", q[0].data, q[0].done, q[0].bytes);
      end
    end
  endtask

  task automatic test_async_reset();
    q.delete();
    bus.buf_full = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(8'(8'h70 + i), 1'b0);
    #2;
    rstN = 1'b0;
    #1;
    vectors++;
    if (bus.buf_idata !== 32'h0) begin miscompares++; $display("FAIL areset_idata got=%h required=0", bus.buf_idata); end
    vectors++;
    if (bus.buf_ivalid !== 1'b0 || bus.blk_done !== 1'b0) begin
      miscompares++; $display("FAIL areset_strobes got=%b/%b required=0/0", bus.buf_ivalid, bus.blk_done);
    end
    vectors++;
    if (bus.blk_bytes !== 17'd0) begin miscompares++; $display("FAIL areset_bytes got=%0d required=0", bus.blk_bytes); end
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL areset_in_ready got=%b required=0", bus.in_ready); end
    bus.buf_full = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rstN = 1'b1;
    step();
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL areset_release_ready got=%b required=1", bus.in_ready); end
    repeat (6) step();
    vectors++;
    if (q.size() != 0) begin miscompares++; $display("FAIL areset_stale got=%0d required=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_partial();
    test_backpressure();
    test_split_64k();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lz4_input_packer.md
# lz4_input_packer

Upstream feeder for the LZ4 dictionary buffer. It accepts the raw input byte stream and packs bytes into 32-bit big-endian words: first byte in [31:23+1], i.e. [31:24]. A small word FIFO absorbs buffer back-pressure. Words are written into the buffer through its `buf_idata`/`buf_ivalid` port, throttled by `buf_full` and `buf_unable`. The block also delimits 64 KB LZ4 blocks and reports each block's byte count.

## Interface
- `FIFO_DEPTH`, 4: word FIFO depth, power of two, ≥2.
- `clk` in 1: system clock, rising edge.
- `rstN` in 1: asynchronous, active-low reset.
- `pk_clear` in 1: synchronous clear, driven together with the buffer's `buf_clear`.
- `in_data` in 8: input byte.
- `in_valid` in 1: `in_data` is valid.
- `in_last` in 1: this byte is the last byte of the stream/block.
- `in_ready` out 1: the byte is accepted when `in_valid && in_ready`.
- `buf_idata` out 32: packed word to the buffer.
- `buf_ivalid` out 1: one-cycle write strobe to the buffer.
- `buf_full` in 1: buffer cannot accept a word (combinational in the buffer).
- `buf_unable` in 1: buffer is clearing; do not write.
- `blk_done` out 1: one-cycle pulse, issued with the final word of a block.
- `blk_bytes` out 17: byte count of the completed block, range 1..65536, held until the next `blk_done`.

## Operation
- **Packing.**
  - A 2-bit lane counter selects the byte lane: lane 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - Each accepted byte is written into the pack register and the lane advances.
- **Word push.** A word is pushed into the FIFO when any of these holds:
  - a byte is accepted in lane 3;
  - `in_last` is accepted;
  - the block byte counter reaches 65536.
- **Push tag and reset.**
  - Each pushed entry carries an `end` tag, set for the last-byte and 65536 cases.
  - After a push, the lane returns to 0 and the pack register to 0.
- **Padding.** A partial final word is zero-padded in its unused low lanes.
- **Block byte counter.**
  - 17 bits; increments per accepted byte.
  - On an `end` push its value (including that byte) is latched into a pending field in the FIFO entry, then the counter resets to 0.
  - A block is therefore never longer than 65536 bytes; the next byte starts a new block.
- **in_ready.** `in_ready = !rst_state && !pk_clear && (fifo_cnt < FIFO_DEPTH)`. One free entry is enough because at most one word is pushed per cycle.
- **Pop.**
  - Pop condition: `fifo_cnt != 0 && !buf_full && !buf_unable`.
  - On a pop, register `buf_idata` = head word and `buf_ivalid` = 1.
  - If the entry is tagged `end`, also register `blk_done` = 1 and `blk_bytes` = entry count.
  - Otherwise `buf_ivalid` = 0, `blk_done` = 0, and `buf_idata` holds its last value.
- **Simultaneous push and pop** in the same cycle: `fifo_cnt` is unchanged, both pointers advance, and no data is lost.
- **Pointers.** FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap modulo `FIFO_DEPTH`. `fifo_cnt` is log2(`FIFO_DEPTH`)+1 bits.
- **pk_clear.**
  - Empties the FIFO and zeroes the lane, pack register, block counter, `buf_ivalid` and `blk_done`.
  - `blk_bytes` is cleared to 0.
  - Bytes presented during the clear cycle are not accepted (`in_ready` = 0).
  - While `buf_unable` is high, bytes may still be accepted until the FIFO fills; no pops occur.
- **Reset (rstN low).** All state clears immediately: FIFO empty, lane 0, counters 0. Outputs after reset:
  - `buf_idata` = 0, `buf_ivalid` = 0, `blk_done` = 0, `blk_bytes` = 0;
  - `in_ready` = 0 while in reset, and 1 from the first cycle after release.

## Timing
- All outputs except `in_ready` are registered. `in_ready` is combinational from registered state and `pk_clear`.
- **Pack latency.** If the 4th byte (or `in_last`) is accepted at edge k, the word is in the FIFO after edge k. With no back-pressure, `buf_ivalid` is high in the cycle after edge k+1.
- **Pack-to-buffer latency** is therefore 2 edges.
- **Throughput.** With continuous input and no back-pressure, one word per 4 cycles; the FIFO never exceeds 1 entry.
- **Back-pressure.**
  - `buf_full` / `buf_unable` are sampled at the pop edge; a high level blocks that edge's pop.
  - The buffer accepts the word registered on the previous edge regardless of `buf_full` changing afterwards.
- **Full FIFO.**
  - When `fifo_cnt` = `FIFO_DEPTH`, `in_ready` is 0 for every lane, including lanes 0–2; this keeps the lane-3 push always safe.
  - `in_ready` returns to 1 in the cycle after the first pop.
- **Ordering.** `blk_done` and `blk_bytes` change in the same cycle as the `buf_ivalid` of the final word, never earlier.

## Test plan
- **Aligned stream.** Bytes 0x00..0x07 back-to-back, `in_last` on 0x07, no back-pressure.
  - Expect two `buf_ivalid` pulses: 0x00010203, then 0x04050607.
  - Expect `blk_done` with `blk_bytes` = 8 on the second pulse.
  - First `buf_ivalid` 2 edges after byte 0x03 is accepted.
- **Partial last word.** Bytes 0xAA, 0xBB, 0xCC with `in_last` on 0xCC.
  - Expect one word 0xAABBCC00 and `blk_bytes` = 3.
- **Back-pressure.**
  - Hold `buf_full` = 1 and stream 20 bytes (4 words filled at `FIFO_DEPTH`=4). Expect `in_ready` to drop after the 16th byte and no `buf_ivalid` pulses.
  - Release `buf_full`. Expect 4 consecutive `buf_ivalid` pulses in order, then the remaining words; no byte is lost or duplicated.
- **64 KB split.** 65540 bytes with `in_last` only on the final byte.
  - Expect `blk_done` with `blk_bytes` = 65536 on word 16384.
  - Expect a second `blk_done` with `blk_bytes` = 4.
- **Clear mid-block.** Inject 6 bytes, pulse `pk_clear` with `buf_unable` high for 8 cycles.
  - Expect FIFO empty, no `buf_ivalid` during `buf_unable`, and `blk_bytes` = 0.
  - The next 4 bytes must produce a lane-0-aligned word.
- **Async reset.** Assert `rstN` low mid-stream with 2 FIFO entries pending.
  - Expect all outputs 0 immediately.
  - After release, `in_ready` = 1 and no stale word is emitted.
